// File: rtl/host_fifo_arb_if.sv
// Port-B write arbiter bundle: requester side in,
// grant/strobe/status side out.
interface host_fifo_arb_if #(
  parameter int NREQ = 4,
  parameter int LW   = 12
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req;
  logic [NREQ*LW-1:0] len;
  logic               stall;
  logic               fifo_rst;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rd;
  logic               hb_wr;
  logic [SW-1:0]      sel;
  logic [LW-1:0]      fill;
  logic               busy;
  logic               xfer_done;
  logic               abort;

  modport master (
    output req, len, stall, fifo_rst,
    input  gnt, rd, hb_wr, sel, fill,
    input  busy, xfer_done, abort
  );

  modport slave (
    input  req, len, stall, fifo_rst,
    output gnt, rd, hb_wr, sel, fill,
    output busy, xfer_done, abort
  );
endinterface

// File: rtl/host_fifo_arb.sv
// Round-robin arbiter moving requester words into the
// host bridge FIFO port B, with fill tracking and abort.
module host_fifo_arb #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 2048,
  parameter int LW    = 12
) (
  input logic            hb_clk,
  input logic            ha_rst,
  host_fifo_arb_if.slave bus
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [LW:0]   DEPTH_W = (LW+1)'(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] ONE     = LW'(1);

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [SW-1:0]   last_q, last_d;
  logic [LW-1:0]   rem_q, rem_d;
  logic [LW-1:0]   fill_q, fill_d;
  logic            busy_q, busy_d;

  logic [LW-1:0]   len_a [NREQ];
  logic [NREQ-1:0] elig;
  logic            found;
  logic [SW-1:0]   win;
  logic            wr;
  logic            kill;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      len_a[i] = bus.len[i*LW +: LW];
      elig[i]  = bus.req[i]
              && (len_a[i] != '0)
              && ({1'b0, len_a[i]}
                  <= DEPTH_W - {1'b0, fill_q});
    end
  end

  // search begins just after the last completed winner
  always_comb begin
    int j;
    logic [SW-1:0] cand;
    found = 1'b0;
    win   = '0;
    j     = 0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(last_q) + k;
      if (j >= NREQ) j = j - NREQ;
      cand = SW'(j);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign kill = bus.fifo_rst && (state_q != S_IDLE);
  assign wr   = (state_q == S_XFER)
             && !bus.stall && !bus.fifo_rst;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    fill_d  = fill_q;
    if (wr && fill_q != DEPTH_L) fill_d = fill_q + ONE;
    if (bus.fifo_rst) fill_d = '0;
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (found) begin
          state_d = S_XFER;
          gnt_d   = NREQ'(1) << win;
          sel_d   = win;
          rem_d   = len_a[win];
          busy_d  = 1'b1;
        end
      end
      state_q == S_XFER: begin
        if (wr) begin
          rem_d = rem_q - ONE;
          if (rem_q == ONE) state_d = S_DONE;
        end
      end
      state_q == S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        last_d  = sel_q;
      end
      default: state_d = S_IDLE;
    endcase
    // abort drops the transfer and keeps the rr pointer
    if (kill) begin
      state_d = S_IDLE;
      gnt_d   = '0;
      busy_d  = 1'b0;
      rem_d   = '0;
      last_d  = last_q;
    end
  end

  always_ff @(posedge hb_clk or posedge ha_rst) begin
    if (ha_rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= SW'(NREQ-1);
      rem_q   <= '0;
      fill_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      fill_q  <= fill_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt       = kill ? '0 : gnt_q;
  assign bus.rd        = gnt_q & {NREQ{wr}};
  assign bus.hb_wr     = wr;
  assign bus.sel       = sel_q;
  assign bus.fill      = fill_q;
  assign bus.busy      = busy_q;
  assign bus.xfer_done = (state_q == S_DONE)
                      && !bus.fifo_rst;
  assign bus.abort     = kill;
endmodule

// File: tb/tb_host_fifo_arb.sv
// Bench for host_fifo_arb: directed scenarios then random
// traffic against a transaction-level arbitration model.
module tb_host_fifo_arb;
  localparam int NREQ  = 4;
  localparam int DEPTH = 2048;
  localparam int LW    = 12;

  logic hb_clk = 1'b0;
  logic ha_rst;
  always #5 hb_clk = ~hb_clk;

  host_fifo_arb_if #(.NREQ(NREQ), .LW(LW)) bus();

  host_fifo_arb #(
    .NREQ (NREQ),
    .DEPTH(DEPTH),
    .LW   (LW)
  ) dut (
    .hb_clk(hb_clk),
    .ha_rst(ha_rst),
    .bus   (bus)
  );

  int ntests = 0;
  int nfail  = 0;

  int         m_last;
  int         m_fill;
  logic [3:0] m_req;
  int         m_len [NREQ];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge hb_clk);
    #1;
  endtask

  task automatic setreq(input logic [3:0] r,
                        input int l0, input int l1,
                        input int l2, input int l3);
    m_req    = r;
    m_len[0] = l0;
    m_len[1] = l1;
    m_len[2] = l2;
    m_len[3] = l3;
    bus.req  = r;
    bus.len  = {LW'(l3), LW'(l2), LW'(l1), LW'(l0)};
  endtask

  // eligible: requesting, nonzero, fits in free space
  function automatic int pick();
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (m_last + k) % NREQ;
      if (m_req[i] && m_len[i] != 0
          && m_len[i] <= DEPTH - m_fill)
        return i;
    end
    return -1;
  endfunction

  // called in the arbitration cycle; returns in DONE
  task automatic xfer(input int idx, input int mode,
                      input bit keep, input string tag);
    int n, w, nst, dc, lim;
    bit done, bad, st;
    logic [3:0] oh;
    n    = m_len[idx];
    w    = 0;
    nst  = 0;
    dc   = -1;
    done = 1'b0;
    bad  = 1'b0;
    oh   = 4'(1 << idx);
    lim  = 3 * n + 20;
    for (int c = 0; c < lim && !done; c++) begin
      nxt();
      if (mode == 1) st = (c == 1 || c == 2);
      else if (mode == 2) st = ($urandom % 3 == 0);
      else st = 1'b0;
      bus.stall = st;
      if (mode == 2 && c == 1) begin
        bus.len = (LW*NREQ)'({$urandom, $urandom});
        if ($urandom % 2 == 0) bus.req = '0;
      end
      #1;
      if (c == 0) begin
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'(oh));
        chk({tag, ".sel"}, 32'(bus.sel), idx);
        chk({tag, ".busy"}, 32'(bus.busy), 1);
      end
      if (bus.xfer_done === 1'b1) begin
        done = 1'b1;
        dc   = c;
      end else begin
        if (bus.hb_wr === 1'b1) w++;
        if (st) nst++;
        if (bus.hb_wr !== !st) bad = 1'b1;
        if (bus.rd !== (bus.hb_wr ? oh : 4'b0))
          bad = 1'b1;
        if (bus.gnt !== oh) bad = 1'b1;
      end
    end
    chk({tag, ".done"}, 32'(done), 1);
    chk({tag, ".words"}, w, n);
    chk({tag, ".span"}, dc, n + nst);
    chk({tag, ".strobes"}, 32'(bad), 0);
    m_fill = m_fill + n;
    if (m_fill > DEPTH) m_fill = DEPTH;
    m_last = idx;
    chk({tag, ".fill"}, 32'(bus.fill), m_fill);
    bus.stall = 1'b0;
    if (!keep) begin
      bus.req = '0;
      m_req   = '0;
    end
  endtask

  task automatic idle_hold(input int ncyc,
                           input string tag);
    int g;
    g = 0;
    repeat (ncyc) begin
      nxt();
      #1;
      if (bus.gnt !== '0 || bus.busy !== 1'b0) g++;
    end
    chk(tag, g, 0);
  endtask

  task automatic frst(input string tag);
    nxt();
    bus.fifo_rst = 1'b1;
    #1;
    chk({tag, ".abort"}, 32'(bus.abort), 0);
    nxt();
    bus.fifo_rst = 1'b0;
    #1;
    m_fill = 0;
    chk({tag, ".fill"}, 32'(bus.fill), 0);
  endtask

  initial begin
    int w, p, room;
    int l [NREQ];
    logic [3:0] r;

    ha_rst       = 1'b1;
    bus.req      = '0;
    bus.len      = '0;
    bus.stall    = 1'b0;
    bus.fifo_rst = 1'b0;
    nxt();
    nxt();
    #1;
    chk("rst.gnt", 32'(bus.gnt), 0);
    chk("rst.rd", 32'(bus.rd), 0);
    chk("rst.hb_wr", 32'(bus.hb_wr), 0);
    chk("rst.sel", 32'(bus.sel), 0);
    chk("rst.fill", 32'(bus.fill), 0);
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.done", 32'(bus.xfer_done), 0);
    chk("rst.abort", 32'(bus.abort), 0);
    ha_rst = 1'b0;
    m_last = NREQ - 1;
    m_fill = 0;

    // single transfer, no stall
    nxt();
    setreq(4'b0001, 5, 0, 0, 0);
    xfer(0, 0, 1'b0, "basic");

    // round robin with all requesters held
    nxt();
    ha_rst = 1'b1;
    #1;
    nxt();
    ha_rst = 1'b0;
    m_last = NREQ - 1;
    m_fill = 0;
    nxt();
    setreq(4'b1111, 1, 1, 1, 1);
    for (int k = 0; k < 8; k++) begin
      xfer(k % 4, 0, k != 7, "rr");
      if (k != 7) nxt();
    end

    // free-space eligibility near full
    frst("full.clr");
    nxt();
    setreq(4'b0001, 2040, 0, 0, 0);
    xfer(0, 0, 1'b0, "full.load");
    nxt();
    setreq(4'b0110, 0, 16, 8, 0);
    xfer(2, 0, 1'b1, "full.fit");
    nxt();
    setreq(4'b0010, 0, 16, 0, 0);
    idle_hold(4, "full.wait");
    frst("full.rst");
    xfer(1, 0, 1'b0, "full.after");

    // stall in the middle of a transfer
    frst("stall.clr");
    nxt();
    setreq(4'b0001, 4, 0, 0, 0);
    xfer(0, 1, 1'b0, "stall");

    // fifo_rst on the final word
    nxt();
    bus.stall = 1'b0;
    setreq(4'b1000, 0, 0, 0, 3);
    nxt();
    #1;
    chk("abort.gnt", 32'(bus.gnt), 8);
    w = int'(bus.hb_wr);
    nxt();
    #1;
    w = w + int'(bus.hb_wr);
    nxt();
    bus.fifo_rst = 1'b1;
    #1;
    chk("abort.wr", 32'(bus.hb_wr), 0);
    chk("abort.rd", 32'(bus.rd), 0);
    chk("abort.gnt0", 32'(bus.gnt), 0);
    chk("abort.pulse", 32'(bus.abort), 1);
    chk("abort.nodone", 32'(bus.xfer_done), 0);
    chk("abort.words", w, 2);
    nxt();
    bus.fifo_rst = 1'b0;
    setreq(4'b0000, 0, 0, 0, 0);
    #1;
    m_fill = 0;
    chk("abort.once", 32'(bus.abort), 0);
    chk("abort.nodone2", 32'(bus.xfer_done), 0);
    chk("abort.fill", 32'(bus.fill), 0);
    chk("abort.busy", 32'(bus.busy), 0);
    chk("abort.gnt1", 32'(bus.gnt), 0);
    nxt();
    setreq(4'b1001, 1, 0, 0, 1);
    xfer(3, 0, 1'b0, "abort.last");

    // asynchronous reset mid-transfer
    nxt();
    setreq(4'b0100, 0, 0, 10, 0);
    nxt();
    nxt();
    nxt();
    #1;
    chk("arst.pre", 32'(bus.hb_wr), 1);
    #1;
    ha_rst = 1'b1;
    #1;
    chk("arst.gnt", 32'(bus.gnt), 0);
    chk("arst.rd", 32'(bus.rd), 0);
    chk("arst.hb_wr", 32'(bus.hb_wr), 0);
    chk("arst.sel", 32'(bus.sel), 0);
    chk("arst.fill", 32'(bus.fill), 0);
    chk("arst.busy", 32'(bus.busy), 0);
    chk("arst.done", 32'(bus.xfer_done), 0);
    chk("arst.abort", 32'(bus.abort), 0);
    nxt();
    ha_rst = 1'b0;
    setreq(4'b0000, 0, 0, 0, 0);
    m_last = NREQ - 1;
    m_fill = 0;
    nxt();
    setreq(4'b1111, 2, 2, 2, 2);
    xfer(0, 0, 1'b0, "arst.next");

    // random traffic, starting close to full
    nxt();
    setreq(4'b0001, 2000, 0, 0, 0);
    xfer(0, 0, 1'b0, "rnd.load");
    for (int it = 0; it < 40; it++) begin
      room = DEPTH - m_fill;
      r    = 4'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        case ($urandom % 8)
          0: l[i] = 0;
          1: l[i] = (room <= 64) ? room
                  : int'(1 + $urandom % 12);
          2: l[i] = (room <= 64) ? room + 1
                  : int'(1 + $urandom % 12);
          default: l[i] = int'(1 + $urandom % 12);
        endcase
      end
      nxt();
      setreq(r, l[0], l[1], l[2], l[3]);
      p = pick();
      if (p < 0) begin
        idle_hold(3, "rnd.hold");
        setreq(4'b0000, 0, 0, 0, 0);
        frst("rnd.frst");
      end else begin
        xfer(p, 2, 1'b0, "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed",
             ntests, nfail);
    $finish;
  end
endmodule

// File: doc/host_fifo_arb.md
HOST_FIFO_ARB -- requirements
Module: host_fifo_arb

Interface
REQ-001 The block SHALL expose parameter NREQ, default 4, meaning the number of port-B write requesters (0=gps, 1=rx, 2=wf, 3=ext).
REQ-002 The block SHALL expose parameter DEPTH, default 2048, meaning the bridge FIFO capacity in 16-bit words.
REQ-003 The block SHALL expose parameter LW, default 12, meaning the width of length and fill fields (clog2(DEPTH)+1).
REQ-004 The block SHALL have port hb_clk  in  1  host-side system clock; all logic clocks on its rising edge.
REQ-005 The block SHALL have port ha_rst  in  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port req  in  NREQ  per-requester transfer request, level, held until done.
REQ-007 The block SHALL have port len  in  NREQ*LW  per-requester word count, slice i = len[i*LW +: LW].
REQ-008 The block SHALL have port stall  in  1  granted requester's data not ready; hold the current word.
REQ-009 The block SHALL have port fifo_rst  in  1  single-cycle pulse from the host_rst decode; empties the FIFO.
REQ-010 The block SHALL have port gnt  out  NREQ  one-hot grant, registered.
REQ-011 The block SHALL have port rd  out  NREQ  one-hot per-word pop strobe to the granted requester.
REQ-012 The block SHALL have port hb_wr  out  1  FIFO port-B write strobe, equal to |rd.
REQ-013 The block SHALL have port sel  out  clog2(NREQ)  hb_din mux select, the index of the granted requester.
REQ-014 The block SHALL have port fill  out  LW  words currently committed to the FIFO.
REQ-015 The block SHALL have port busy, xfer_done, abort  out  1 each  XFER active / completion pulse / abort pulse.

Function
REQ-016 The FSM SHALL have states IDLE, XFER, DONE.
REQ-017 In IDLE, a requester SHALL be eligible iff req[i]=1, len[i]!=0 and len[i] <= DEPTH-fill.
REQ-018 Arbitration SHALL be round-robin: search starts at last+1 mod NREQ, where last is the previous completed winner.
REQ-019 When an eligible requester is found in IDLE at cycle N, the block SHALL assert gnt, sel and busy at N+1 and enter XFER.
REQ-020 The block SHALL register len of the winner into a remaining-word counter at grant; later len changes SHALL be ignored.
REQ-021 If no requester is eligible, the block SHALL stay in IDLE; ineligible requests SHALL NOT be granted and SHALL NOT be dropped.
REQ-022 Zero-length requests SHALL never be granted.
REQ-023 In XFER, each cycle with stall=0 SHALL assert rd[g] and hb_wr, decrement remaining and increment fill.
REQ-024 In XFER, a cycle with stall=1 SHALL assert neither rd nor hb_wr, and counters SHALL hold.
REQ-025 First write latency SHALL be 1 cycle from the arbitration cycle; the sustained rate SHALL be 1 word/cycle.
REQ-026 After the word with remaining=1 is written, the FSM SHALL enter DONE.
REQ-027 In DONE, the block SHALL pulse xfer_done for exactly 1 cycle, set last=g, deassert gnt and busy at the next edge, and return to IDLE.
REQ-028 The minimum gap between back-to-back grants SHALL be 2 cycles (DONE, IDLE).
REQ-029 A requester deasserting req during XFER SHALL NOT end the transfer early.
REQ-030 fill SHALL saturate at DEPTH and SHALL never wrap; fill overflow SHALL be impossible by the eligibility rule of REQ-017.
REQ-031 fifo_rst SHALL set fill=0 at the next edge in any state.
REQ-032 fifo_rst in XFER or DONE SHALL force IDLE, clear gnt, rd and hb_wr in that same cycle (combinational gating), and pulse abort for 1 cycle.
REQ-033 On abort, xfer_done SHALL NOT pulse and last SHALL be unchanged.
REQ-034 fifo_rst coincident with the final word SHALL win: the word is not written, abort pulses, and xfer_done does not pulse.
REQ-035 fifo_rst in IDLE SHALL only clear fill; abort SHALL stay 0.

Reset
REQ-036 While ha_rst=1, the block SHALL hold state=IDLE, gnt=0, rd=0, hb_wr=0, sel=0, fill=0, busy=0, xfer_done=0, abort=0, remaining=0, last=NREQ-1.
REQ-037 Reset mid-transfer SHALL discard the transfer with no xfer_done or abort pulse.
REQ-038 After ha_rst deassertion, the first arbitration SHALL favour requester 0.

Verification
REQ-039 Bench SHALL drive req=0001, len0=5, stall=0 -> gnt=0001 at N+1, 5 consecutive rd[0]/hb_wr pulses, xfer_done at N+6, fill=5.
REQ-040 Bench SHALL hold req=1111, all len=1, for 8 grants -> grant order 0,1,2,3,0,1,2,3.
REQ-041 Bench SHALL drive fill=2040, req=0110, len1=16, len2=8 -> requester 2 granted, requester 1 waits; after fifo_rst, requester 1 granted.
REQ-042 Bench SHALL drive len0=4 with stall high on cycles 2-3 of XFER -> 4 writes over 6 cycles; fill=4 at done.
REQ-043 Bench SHALL drive fifo_rst on the last word of a len=3 transfer -> only 2 writes, abort=1 for 1 cycle, xfer_done=0, fill=0.
REQ-044 Bench SHALL assert ha_rst asynchronously mid-XFER -> all outputs 0 immediately; next grant goes to requester 0.
